// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: decode-stage inputs and stall/flush control outputs of the hazard controller.
// Ports: fd_ir, dx_ir (instructions in F/D and D/X), branch_taken, md_ready (mult/div done),
// pc_en/fd_en/dx_en/xm_en/mw_en latch enables, fd/dx/xm_flush nop inserts,
// md_start mult/div start pulse, stall_cnt stall cycle count.
interface pipeline_ctrl_if;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        branch_taken;
  logic        md_ready;
  logic        pc_en;
  logic        fd_en;
  logic        dx_en;
  logic        xm_en;
  logic        mw_en;
  logic        fd_flush;
  logic        dx_flush;
  logic        xm_flush;
  logic        md_start;
  logic [15:0] stall_cnt;
  modport master (
    output fd_ir, dx_ir, branch_taken, md_ready,
    input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start, stall_cnt
  );
  modport slave (
    input  fd_ir, dx_ir, branch_taken, md_ready,
    output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline hazard controller (load-use bubble, taken-branch flush, mult/div stall).
// Ports: clk, rst_n (async active-low), p (pipeline_ctrl_if.slave) carrying instructions,
// branch/mult-div status in and all enables, flushes, md_start and stall_cnt out.
// Optional: define PIPELINE_CTRL_STALL_CNT_EN to build the saturating stall counter;
// otherwise stall_cnt is tied to zero.
module pipeline_ctrl (
  input logic clk,
  input logic rst_n,
  pipeline_ctrl_if.slave p
);
  typedef enum logic {IDLE, MD_BUSY} state_t;
  state_t state;
  logic [4:0] dx_op, dx_rd, dx_alu, fd_op, fd_rd, fd_rs, fd_rt;
  logic md_op, load_use, idle, md_hold, br, lu, pc_en;
  assign dx_op  = p.dx_ir[31:27];
  assign dx_rd  = p.dx_ir[26:22];
  assign dx_alu = p.dx_ir[6:2];
  assign fd_op  = p.fd_ir[31:27];
  assign fd_rd  = p.fd_ir[26:22];
  assign fd_rs  = p.fd_ir[21:17];
  assign fd_rt  = p.fd_ir[16:12];
  assign md_op = dx_op == 5'b00000 && (dx_alu == 5'b00110 || dx_alu == 5'b00111);
  assign load_use = dx_op == 5'b01000 && dx_rd != 5'd0 &&
                    (fd_rs == dx_rd || (fd_op == 5'b00000 && fd_rt == dx_rd) ||
                     (fd_op == 5'b00111 && fd_rd == dx_rd));
  assign idle = state == IDLE;
  // Everything is gated with rst_n so the pipeline free-runs with no flushes while held in reset.
  // md_op outranks a taken branch, which outranks a load-use bubble.
  assign md_hold = rst_n && (idle ? md_op : !p.md_ready);
  assign br      = rst_n && idle && !md_op && p.branch_taken;
  assign lu      = rst_n && idle && !md_op && !p.branch_taken && load_use;
  assign pc_en      = !(md_hold || lu);
  assign p.pc_en    = pc_en;
  assign p.fd_en    = pc_en;
  assign p.dx_en    = !md_hold;
  assign p.xm_en    = 1'b1;
  assign p.mw_en    = 1'b1;
  assign p.fd_flush = br;
  assign p.dx_flush = br || lu;
  assign p.xm_flush = md_hold;
  // Leaving MD_BUSY enables dx, so the mult/div instruction advances and cannot restart itself.
  assign p.md_start = rst_n && idle && md_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= idle ? (md_op ? MD_BUSY : IDLE) : (p.md_ready ? IDLE : MD_BUSY);
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!pc_en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign p.stall_cnt = cnt;
`else
  assign p.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sc = '0;
  logic [8:0] ctl;
  pipeline_ctrl_if b ();
  pipeline_ctrl dut (.clk(clk), .rst_n(rst_n), .p(b.slave));
  always #5 clk = ~clk;
  // {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start}
  assign ctl = {b.pc_en, b.fd_en, b.dx_en, b.xm_en, b.mw_en, b.fd_flush, b.dx_flush, b.xm_flush, b.md_start};
  localparam logic [8:0] NORM = 9'b11111_000_0;
  localparam logic [8:0] LU   = 9'b00111_010_0;
  localparam logic [8:0] BR   = 9'b11111_110_0;
  localparam logic [8:0] MDS  = 9'b00011_001_1;
  localparam logic [8:0] MDB  = 9'b00011_001_0;
  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, alu);
    return {5'b00000, rd, rs, rt, 5'b0, alu, 2'b0};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'b0};
  endfunction
  function automatic logic [15:0] exp_cnt();
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    return sc;
`else
    return 16'h0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Check controls mid-cycle, model the counter across the edge, then check the count.
  task automatic cyc(input string tag, input logic [8:0] e);
    #1 chk(tag, {23'b0, ctl}, {23'b0, e});
    if (!e[8] && sc != 16'hFFFF) sc++;
    @(posedge clk);
    #1 chk({tag, "_cnt"}, {16'b0, b.stall_cnt}, {16'b0, exp_cnt()});
  endtask
  initial begin
    b.fd_ir = '0;
    b.dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    b.branch_taken = 1'b0;
    b.md_ready = 1'b0;
    @(posedge clk);
    #1 chk("rst_ctl", {23'b0, ctl}, {23'b0, NORM});
    chk("rst_cnt", {16'b0, b.stall_cnt}, 32'h0);
    b.dx_ir = '0;
    rst_n = 1'b1;
    cyc("idle", NORM);
    b.dx_ir = itype(5'b01000, 5'd5, 5'd1, 5'd0);
    b.fd_ir = rtype(5'd1, 5'd5, 5'd2, 5'd0);
    cyc("lu_rs", LU);
    b.dx_ir = '0;
    cyc("lu_after", NORM);
    b.dx_ir = itype(5'b01000, 5'd5, 5'd1, 5'd0);
    b.fd_ir = rtype(5'd1, 5'd2, 5'd5, 5'd0);
    cyc("lu_rt", LU);
    b.fd_ir = itype(5'b00111, 5'd5, 5'd3, 5'd0);
    cyc("lu_sw", LU);
    b.fd_ir = itype(5'b01000, 5'd1, 5'd2, 5'd5);
    cyc("no_lu_itype_rt", NORM);
    b.fd_ir = rtype(5'd1, 5'd2, 5'd3, 5'd0);
    cyc("no_lu_indep", NORM);
    b.dx_ir = itype(5'b01000, 5'd0, 5'd1, 5'd0);
    b.fd_ir = rtype(5'd1, 5'd0, 5'd2, 5'd0);
    cyc("lw_r0", NORM);
    b.dx_ir = itype(5'b01000, 5'd5, 5'd1, 5'd0);
    b.fd_ir = rtype(5'd1, 5'd5, 5'd2, 5'd0);
    b.branch_taken = 1'b1;
    cyc("br_over_lu", BR);
    b.branch_taken = 1'b0;
    b.dx_ir = '0;
    b.fd_ir = '0;
    b.dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    for (int i = 0; i < 32; i++) cyc(i == 0 ? "mul_start" : "mul_busy", i == 0 ? MDS : MDB);
    b.md_ready = 1'b1;
    cyc("mul_release", NORM);
    b.dx_ir = '0;
    b.md_ready = 1'b0;
    cyc("mul_after", NORM);
    b.dx_ir = rtype(5'd4, 5'd1, 5'd2, 5'b00111);
    b.branch_taken = 1'b1;
    cyc("div_over_br", MDS);
    b.branch_taken = 1'b0;
    b.md_ready = 1'b1;
    cyc("div_release", NORM);
    b.dx_ir = '0;
    b.md_ready = 1'b0;
    b.dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    cyc("mul2_start", MDS);
    #1 chk("mul2_busy", {23'b0, ctl}, {23'b0, MDB});
    #2 rst_n = 1'b0;
    sc = '0;
    #1 chk("midrst_ctl", {23'b0, ctl}, {23'b0, NORM});
    chk("midrst_cnt", {16'b0, b.stall_cnt}, 32'h0);
    b.dx_ir = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    cyc("post_rst_idle", NORM);
    b.dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    cyc("post_rst_mul", MDS);
    b.md_ready = 1'b1;
    cyc("post_rst_release", NORM);
    b.dx_ir = '0;
    b.md_ready = 1'b0;
    b.dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    repeat (70000) begin
      @(posedge clk);
      if (sc != 16'hFFFF) sc++;
    end
    #1 chk("sat_cnt", {16'b0, b.stall_cnt}, {16'b0, exp_cnt()});
    chk("sat_ctl", {23'b0, ctl}, {23'b0, MDB});
    b.md_ready = 1'b1;
    cyc("sat_release", NORM);
    b.dx_ir = '0;
    b.md_ready = 1'b0;
    cyc("sat_after", NORM);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
